// File: rtl/kplic_reg_arbiter.sv
// Round-robin arbiter that gives the KPLIC register port to either the core or the debug bus,
// one strobe per access. Optional grant locking is enabled by defining KPLIC_ARB_LOCK_EN.

`ifndef KPLIC_DATA_WIDTH
`define KPLIC_DATA_WIDTH 32
`endif

module kplic_reg_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = `KPLIC_DATA_WIDTH,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              kplic_clk,
  input  logic              kplic_rstn,

  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq0_lock,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic              rq1_lock,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic              valid_reg_read,
  output logic              valid_reg_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q;
  logic              owner_q;
  logic              is_write_q;
  logic              rr_last_q;
  logic [DATA_W-1:0] rdata_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_lock;

`ifdef KPLIC_ARB_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  logic            lock_act_q;
  logic            lock_own_q;
  logic [CntW-1:0] lock_cnt_q;
  logic [CntW-1:0] lock_cnt_nxt;
`else
  localparam int unsigned UnusedLockMax = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = rq0_lock ^ rq1_lock;
`endif

  // Arbitration is only live in idle; the loser always sees ready low.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == StIdle) begin
      if (rq0_valid && rq1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ~rr_last_q;
      end else if (rq0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (rq1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
`ifdef KPLIC_ARB_LOCK_EN
      // A held lock overrides round-robin: only the lock owner may be granted.
      if (lock_act_q) begin
        gnt_id    = lock_own_q;
        gnt_valid = lock_own_q ? rq1_valid : rq0_valid;
      end
`endif
    end
  end

  assign rq0_ready = gnt_valid & ~gnt_id;
  assign rq1_ready = gnt_valid & gnt_id;

  assign sel_write = gnt_id ? rq1_write : rq0_write;
  assign sel_addr  = gnt_id ? rq1_addr  : rq0_addr;
  assign sel_wdata = gnt_id ? rq1_wdata : rq0_wdata;
  assign sel_lock  = gnt_id ? rq1_lock  : rq0_lock;

`ifdef KPLIC_ARB_LOCK_EN
  always_comb begin
    if (lock_act_q && (lock_own_q == gnt_id)) begin
      lock_cnt_nxt = lock_cnt_q + CntW'(1);
    end else begin
      lock_cnt_nxt = CntW'(1);
    end
  end
`else
  logic unused_sel_lock;
  assign unused_sel_lock = sel_lock;
`endif

  assign rsp0_rdata = rdata_q;
  assign rsp1_rdata = rdata_q;

  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      state_q         <= StIdle;
      owner_q         <= 1'b0;
      is_write_q      <= 1'b0;
      rr_last_q       <= 1'b1;
      rdata_q         <= '0;
      rsp0_valid      <= 1'b0;
      rsp1_valid      <= 1'b0;
      valid_reg_read  <= 1'b0;
      valid_reg_write <= 1'b0;
      addr            <= '0;
      write_data      <= '0;
`ifdef KPLIC_ARB_LOCK_EN
      lock_act_q      <= 1'b0;
      lock_own_q      <= 1'b0;
      lock_cnt_q      <= '0;
`endif
    end else begin
      // Strobes default low so each accept yields exactly one pulse.
      valid_reg_read  <= 1'b0;
      valid_reg_write <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            owner_q         <= gnt_id;
            is_write_q      <= sel_write;
            addr            <= sel_addr;
            write_data      <= sel_wdata;
            valid_reg_read  <= ~sel_write;
            valid_reg_write <= sel_write;
            state_q         <= StIssue;
`ifdef KPLIC_ARB_LOCK_EN
            if (sel_lock && (lock_cnt_nxt < CntW'(LOCK_MAX))) begin
              lock_act_q <= 1'b1;
              lock_own_q <= gnt_id;
              lock_cnt_q <= lock_cnt_nxt;
            end else begin
              lock_act_q <= 1'b0;
              lock_cnt_q <= '0;
            end
`endif
          end
        end
        StIssue: begin
          rdata_q    <= (!is_write_q && read_data_valid) ? read_data : '0;
          rsp0_valid <= ~owner_q;
          rsp1_valid <= owner_q;
          state_q    <= StResp;
        end
        StResp: begin
          if (owner_q ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rr_last_q  <= owner_q;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kplic_reg_arbiter.sv
// Directed bench for kplic_reg_arbiter: reset, reads, writes, alternation, stalls, MPPI claim,
// reset mid-access, and (with KPLIC_ARB_LOCK_EN) locked grants.
module tb_kplic_reg_arbiter;

  localparam logic [11:0] MppiOff = 12'h200;
  localparam logic [31:0] MppiVal = 32'h0000_0017;
  localparam logic [31:0] RegVal  = 32'hA5A5_0001;

  logic        kplic_clk = 1'b0;
  logic        kplic_rstn = 1'b0;
  logic        rq0_valid = 0, rq0_write = 0, rq0_lock = 0, rsp0_ready = 0;
  logic        rq1_valid = 0, rq1_write = 0, rq1_lock = 0, rsp1_ready = 0;
  logic [11:0] rq0_addr = '0, rq1_addr = '0;
  logic [31:0] rq0_wdata = '0, rq1_wdata = '0;
  logic        rq0_ready, rq1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        valid_reg_read, valid_reg_write;
  logic [11:0] addr;
  logic [31:0] write_data, read_data;
  logic        read_data_valid = 1'b1;

  int errors = 0, checks = 0;
  int rd_cnt = 0, wr_cnt = 0, dual_cnt = 0, claim_cnt = 0;
  int wr_base, claim_base;

  always #5 kplic_clk = ~kplic_clk;

  assign read_data = (addr == MppiOff) ? MppiVal : RegVal;

  kplic_reg_arbiter dut (
    .kplic_clk       (kplic_clk),
    .kplic_rstn      (kplic_rstn),
    .rq0_valid       (rq0_valid),
    .rq0_ready       (rq0_ready),
    .rq0_write       (rq0_write),
    .rq0_addr        (rq0_addr),
    .rq0_wdata       (rq0_wdata),
    .rq0_lock        (rq0_lock),
    .rsp0_valid      (rsp0_valid),
    .rsp0_ready      (rsp0_ready),
    .rsp0_rdata      (rsp0_rdata),
    .rq1_valid       (rq1_valid),
    .rq1_ready       (rq1_ready),
    .rq1_write       (rq1_write),
    .rq1_addr        (rq1_addr),
    .rq1_wdata       (rq1_wdata),
    .rq1_lock        (rq1_lock),
    .rsp1_valid      (rsp1_valid),
    .rsp1_ready      (rsp1_ready),
    .rsp1_rdata      (rsp1_rdata),
    .valid_reg_read  (valid_reg_read),
    .valid_reg_write (valid_reg_write),
    .addr            (addr),
    .write_data      (write_data),
    .read_data       (read_data),
    .read_data_valid (read_data_valid)
  );

  // Strobe monitor; an MPPI claim is a read strobe on the MPPI offset.
  always @(negedge kplic_clk) begin
    if (valid_reg_read) rd_cnt <= rd_cnt + 1;
    if (valid_reg_write) wr_cnt <= wr_cnt + 1;
    if (valid_reg_read && valid_reg_write) dual_cnt <= dual_cnt + 1;
    if (valid_reg_read && addr == MppiOff) claim_cnt <= claim_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge kplic_clk);
    #1;
  endtask

  task automatic apply_reset();
    kplic_rstn = 1'b0;
    tick();
    tick();
    chk("rst_rd_strobe", valid_reg_read, 0);
    chk("rst_wr_strobe", valid_reg_write, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_addr", addr, 0);
    kplic_rstn = 1'b1;
  endtask

  initial begin
    // Reset then a single core read.
    apply_reset();
    chk("rst_rdata", rsp0_rdata, 0);
    rq0_valid = 1; rq0_write = 0; rq0_addr = 12'h004;
    #1;
    chk("t1_rq0_ready", rq0_ready, 1);
    chk("t1_rq1_ready", rq1_ready, 0);
    tick();
    rq0_valid = 0; rq0_addr = 12'h3FF;
    #1;
    chk("t1_rd_strobe", valid_reg_read, 1);
    chk("t1_wr_strobe", valid_reg_write, 0);
    chk("t1_addr", addr, 12'h004);
    tick(); #1;
    chk("t1_rd_strobe_off", valid_reg_read, 0);
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_rdata", rsp0_rdata, RegVal);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    tick(); #1;
    chk("t1_rsp0_hold", rsp0_valid, 1);
    rsp0_ready = 1;
    tick(); #1;
    chk("t1_rsp0_done", rsp0_valid, 0);
    chk("t1_rd_count", rd_cnt, 1);
    rsp0_ready = 0;

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    apply_reset();
    rq0_valid = 1; rq0_write = 0; rq0_addr = 12'h020;
    rq1_valid = 1; rq1_write = 1; rq1_addr = 12'h010; rq1_wdata = 32'h11;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rq0_ready", rq0_ready, (i % 2) == 0);
      chk("t2_rq1_ready", rq1_ready, (i % 2) == 1);
      tick(); #1;
      chk("t2_rd_strobe", valid_reg_read, (i % 2) == 0);
      chk("t2_wr_strobe", valid_reg_write, (i % 2) == 1);
      chk("t2_addr", addr, ((i % 2) == 0) ? 12'h020 : 12'h010);
      tick(); #1;
      chk("t2_rsp0_valid", rsp0_valid, (i % 2) == 0);
      chk("t2_rsp1_valid", rsp1_valid, (i % 2) == 1);
      tick();
    end
    chk("t2_no_dual", dual_cnt, 0);

    // Debug write with a stalled response; core must wait.
    rq0_valid = 0;
    rq1_valid = 1; rq1_write = 1; rq1_addr = 12'h00C; rq1_wdata = 32'h5;
    rsp1_ready = 0; rsp0_ready = 1;
    wr_base = wr_cnt;
    #1;
    chk("t3_rq1_ready", rq1_ready, 1);
    tick();
    rq1_valid = 0; rq0_valid = 1; rq0_write = 0; rq0_addr = 12'h020;
    #1;
    chk("t3_wr_strobe", valid_reg_write, 1);
    chk("t3_wdata", write_data, 32'h5);
    chk("t3_addr", addr, 12'h00C);
    chk("t3_rq0_blocked_issue", rq0_ready, 0);
    tick(); #1;
    chk("t3_rsp1_valid", rsp1_valid, 1);
    chk("t3_rsp1_rdata", rsp1_rdata, 0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("t3_rq0_stalled", rq0_ready, 0);
      chk("t3_rsp1_stable", rsp1_valid, 1);
    end
    rsp1_ready = 1;
    tick(); #1;
    chk("t3_rsp1_taken", rsp1_valid, 0);
    chk("t3_rq0_ready", rq0_ready, 1);
    chk("t3_wr_count", wr_cnt - wr_base, 1);
    rsp1_ready = 0;
    tick();
    rq0_valid = 0;
    tick();
    tick();

    // MPPI read must claim exactly once even with a stalled response.
    claim_base = claim_cnt;
    rq0_valid = 1; rq0_write = 0; rq0_addr = MppiOff; rsp0_ready = 0;
    tick();
    rq0_valid = 0;
    tick(); #1;
    chk("t4_rsp0_valid", rsp0_valid, 1);
    chk("t4_mppi_rdata", rsp0_rdata, MppiVal);
    repeat (3) tick();
    rsp0_ready = 1;
    tick(); #1;
    chk("t4_claims", claim_cnt - claim_base, 1);
    chk("t4_rsp0_done", rsp0_valid, 0);
    rsp0_ready = 0;

    // Reset during ISSUE.
    rq0_valid = 1; rq0_addr = 12'h004;
    tick();
    rq0_valid = 0;
    #1;
    chk("t5_issue_strobe", valid_reg_read, 1);
    kplic_rstn = 0;
    #1;
    chk("t5_rst_issue_strobe", valid_reg_read, 0);
    chk("t5_rst_issue_rsp0", rsp0_valid, 0);
    tick();
    kplic_rstn = 1;
    // Reset during RESP.
    rq1_valid = 1; rq1_write = 1; rq1_addr = 12'h00C;
    tick();
    rq1_valid = 0;
    tick(); #1;
    chk("t5_resp_rsp1", rsp1_valid, 1);
    kplic_rstn = 0;
    #1;
    chk("t5_rst_resp_rsp1", rsp1_valid, 0);
    chk("t5_rst_resp_strobe", valid_reg_write, 0);
    tick();
    kplic_rstn = 1;
    rq0_valid = 1; rq0_write = 0; rq0_addr = 12'h004;
    rq1_valid = 1;
    #1;
    chk("t5_tie_rq0", rq0_ready, 1);
    chk("t5_tie_rq1", rq1_ready, 0);
    tick();
    rq0_valid = 0; rq1_valid = 0;
    tick(); #1;
    chk("t5_rsp0_valid", rsp0_valid, 1);
    chk("t5_rsp0_rdata", rsp0_rdata, RegVal);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;

`ifdef KPLIC_ARB_LOCK_EN
    // Core holds the lock; debug bus gets in only after 8 locked grants.
    apply_reset();
    rq0_valid = 1; rq0_lock = 1; rq0_write = 0; rq0_addr = 12'h004;
    rq1_valid = 1; rq1_write = 1; rq1_addr = 12'h010;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t6_lock_rq0", rq0_ready, 1);
      chk("t6_lock_rq1", rq1_ready, 0);
      tick(); tick(); tick();
    end
    #1;
    chk("t6_release_rq1", rq1_ready, 1);
    chk("t6_release_rq0", rq0_ready, 0);
    tick();
    rq0_valid = 0; rq1_valid = 0; rq0_lock = 0;
    tick(); tick();
`endif

    chk("final_no_dual", dual_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
